// File: rtl/redcpu_fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package redcpu_fetch_pkg;

    localparam int FETCH_ADDR_W = 8;
    localparam int FETCH_DATA_W = 16;

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_prefetch_buf.sv
// One-entry prefetch buffer holding the word at pc+1, with hit and invalidate logic.
// Latency: fill visible the cycle after i_fill; hit is combinational on i_adv.
// Backpressure: none; any PC advance consumes (hit) or drops (miss) the entry.
module fetch_prefetch_buf
    import redcpu_fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_fill,
    input  logic [ADDR_W-1:0] i_fill_addr,
    input  logic [DATA_W-1:0] i_fill_data,
    input  logic              i_adv,
    input  logic [ADDR_W-1:0] i_next_pc,
    output logic              o_pf_valid,
    output logic [DATA_W-1:0] o_pf_data,
    output logic              o_hit
);

    logic              r_pf_valid;
    logic [ADDR_W-1:0] r_pf_addr;
    logic [DATA_W-1:0] r_pf_data;

    assign o_hit      = i_adv && r_pf_valid && (r_pf_addr == i_next_pc);
    assign o_pf_valid = r_pf_valid;
    assign o_pf_data  = r_pf_data;

    // Entry state: any PC move retires the entry (consumed on hit, stale otherwise)
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pf_valid <= 1'b0;
            r_pf_addr  <= '0;
            r_pf_data  <= '0;
        end else if (i_adv) begin
            r_pf_valid <= 1'b0;
        end else if (i_fill) begin
            r_pf_valid <= 1'b1;
            r_pf_addr  <= i_fill_addr;
            r_pf_data  <= i_fill_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads one word per request over a rd/ack bus. Optional FETCH_PREFETCH_EN.
// Latency: RAM_ready rises the cycle after the accepted mem_ack (zero-wait: counter_en t -> ready t+2).
// Backpressure: mem_rd held until mem_ack; stale acks (PC moved) are dropped and the fetch reissued.
module fetch_unit
    import redcpu_fetch_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                DATA_W   = FETCH_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              counter_en,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instruction,
    output logic              RAM_ready,
    output logic [ADDR_W-1:0] pc
);

    fetch_state_t      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_inc, w_pc_nxt;
    logic [ADDR_W-1:0] r_req_addr, w_req_addr_nxt;
    logic [DATA_W-1:0] r_instr, w_instr_nxt;
    logic              w_mem_rd;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_pf_valid;
    logic              w_pf_hit;
    logic [DATA_W-1:0] w_pf_data;

    // Acks are always judged against the PC as it will be after this cycle's advance
    assign w_pc_inc = r_pc + ADDR_W'(1);
    assign w_pc_nxt = counter_en ? w_pc_inc : r_pc;

`ifdef FETCH_PREFETCH_EN
    localparam bit PF_EN = 1'b1;
    logic w_pf_fill;

    // An ack arriving together with an advance is promoted directly instead of buffered
    assign w_pf_fill = (r_state == S_VALID) && w_mem_rd && mem_ack && !counter_en;

    fetch_prefetch_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_pf (
        .clk         (clk),
        .rst         (rst),
        .i_fill      (w_pf_fill),
        .i_fill_addr (w_pc_inc),
        .i_fill_data (mem_rdata),
        .i_adv       (counter_en),
        .i_next_pc   (w_pc_inc),
        .o_pf_valid  (w_pf_valid),
        .o_pf_data   (w_pf_data),
        .o_hit       (w_pf_hit)
    );
`else
    localparam bit PF_EN = 1'b0;

    assign w_pf_valid = 1'b0;
    assign w_pf_hit   = 1'b0;
    assign w_pf_data  = '0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, bus request and datapath updates
    always_comb begin
        w_state_nxt    = r_state;
        w_req_addr_nxt = r_req_addr;
        w_instr_nxt    = r_instr;
        w_mem_rd       = 1'b0;
        w_mem_addr     = r_req_addr;
        case (r_state)
            S_RST: begin
                w_state_nxt    = S_REQ;
                w_req_addr_nxt = w_pc_nxt;
            end
            S_REQ: begin
                w_mem_rd = 1'b1;
                if (mem_ack) begin
                    if (r_req_addr == w_pc_nxt) begin
                        w_instr_nxt = mem_rdata;
                        w_state_nxt = S_VALID;
                    end else begin
                        w_req_addr_nxt = w_pc_nxt;
                    end
                end
            end
            S_VALID: begin
                // With prefetch the idle bus is used to read pc+1 until the buffer holds it
                if (PF_EN) begin
                    w_mem_rd   = !w_pf_valid;
                    w_mem_addr = w_pc_inc;
                end
                if (counter_en) begin
                    if (w_pf_hit) begin
                        w_instr_nxt = w_pf_data;
                    end else if (w_mem_rd && mem_ack) begin
                        w_instr_nxt = mem_rdata;
                    end else begin
                        // An outstanding prefetch already targets pc+1, so mem_addr stays put
                        w_state_nxt    = S_REQ;
                        w_req_addr_nxt = w_pc_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = S_RST;
            end
        endcase
    end

    // PC, request address and instruction registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_instr    <= '0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_req_addr <= w_req_addr_nxt;
            r_instr    <= w_instr_nxt;
        end
    end

    assign mem_rd      = w_mem_rd;
    assign mem_addr    = w_mem_addr;
    assign instruction = r_instr;
    assign RAM_ready   = (r_state == S_VALID);
    assign pc          = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a bus-responder memory and a rule-level reference model.
// Latency: n/a.
// Backpressure: memory ack delay is programmable per test (0 = zero-wait).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        counter_en = 1'b0;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [15:0] instruction;
    logic        RAM_ready;
    logic [7:0]  pc;

    int total = 0;
    int bad   = 0;

    bit          auto_mem = 1'b1;
    int          ack_dly  = 0;
    bit          man_ack  = 1'b0;
    logic [15:0] man_data = '0;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W   (8),
        .DATA_W   (16),
        .RESET_PC (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .counter_en  (counter_en),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instruction (instruction),
        .RAM_ready   (RAM_ready),
        .pc          (pc)
    );

    // Memory contents: addr 0 holds 16'h1234, every other addr a unique word
    function automatic logic [15:0] memw(input logic [7:0] a);
        return (a == 8'h00) ? 16'h1234 : (16'hA500 + {8'h00, a});
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        counter_en = 1'b1;
        tick();
        counter_en = 1'b0;
    endtask

    task automatic wait_ready(input string nm, input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (RAM_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(nm, {31'd0, ok}, 32'd1);
    endtask

    // Memory responder: acks ack_dly cycles after the request becomes visible
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!auto_mem) begin
                mem_ack   = man_ack;
                mem_rdata = man_data;
                cnt = 0;
            end else if (!mem_rd) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else if (cnt >= ack_dly) begin
                mem_ack   = 1'b1;
                mem_rdata = memw(mem_addr);
                cnt = 0;
            end else begin
                mem_ack = 1'b0;
                cnt++;
            end
        end
    end

    // Reference model from the protocol rules; compares once per cycle on the falling edge
    initial begin
        bit          mv = 1'b0;
        bit          m_inrst = 1'b0;
        int          m_pc = 0;
        bit          m_ready = 1'b0;
        bit          m_rd = 1'b0;
        int          m_addr = 0;
        logic [15:0] m_instr = '0;
        int          npc;
        bit          hit;
        forever begin
            @(negedge clk);
            if (mv) begin
                chk("pc", {24'd0, pc}, m_pc);
`ifndef FETCH_PREFETCH_EN
                chk("RAM_ready", {31'd0, RAM_ready}, {31'd0, m_ready});
                chk("mem_rd", {31'd0, mem_rd}, {31'd0, m_rd});
                if (m_rd || m_inrst) chk("mem_addr", {24'd0, mem_addr}, m_addr);
                chk("instruction", {16'd0, instruction}, {16'd0, m_instr});
`else
                if (RAM_ready) chk("ready_word", {16'd0, instruction}, {16'd0, memw(pc)});
`endif
            end
            if (!rst) begin
                mv = 1'b1; m_inrst = 1'b1; m_pc = 0; m_ready = 1'b0;
                m_rd = 1'b0; m_addr = 0; m_instr = '0;
            end else if (mv) begin
                npc = (m_pc + int'(counter_en)) % 256;
                hit = m_rd && mem_ack && (m_addr == npc);
                if (hit) m_instr = mem_rdata;
                if (!(m_rd && !mem_ack)) m_addr = npc;
                m_ready = (m_ready && !counter_en) || hit;
                m_rd    = !m_ready;
                m_pc    = npc;
                m_inrst = 1'b0;
            end
        end
    end

    initial begin
        int rd_cyc;
        bit got;
        bit ack_prev;
        bit saw6;

        // Reset values
        repeat (3) tick();
        chk("rst_pc", {24'd0, pc}, 32'h0);
        chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'h0);
        chk("rst_ready", {31'd0, RAM_ready}, 32'd0);
        chk("rst_instr", {16'd0, instruction}, 32'h0);

        // First fetch, memory acking 3 cycles after mem_rd rises
        ack_dly = 3;
        rst = 1'b1;
        rd_cyc = 0; got = 1'b0; ack_prev = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (RAM_ready) begin
                got = 1'b1;
                ack_prev = mem_ack;
                break;
            end
            if (mem_rd) begin
                rd_cyc++;
                if (rd_cyc == 1) chk("t1_addr", {24'd0, mem_addr}, 32'h0);
            end
        end
        chk("t1_ready", {31'd0, got}, 32'd1);
        chk("t1_rd_cycles", rd_cyc, 32'd4);
        chk("t1_ack_prev_cycle", {31'd0, ack_prev}, 32'd1);
        chk("t1_instr", {16'd0, instruction}, 32'h1234);

`ifdef FETCH_PREFETCH_EN
        // Zero-wait prefetch of pc+1, then a zero-bubble advance
        ack_dly = 0;
        repeat (3) tick();
        chk("pf_bus_idle", {31'd0, mem_rd}, 32'd0);
        pulse();
        chk("pf_ready_kept", {31'd0, RAM_ready}, 32'd1);
        chk("pf_instr1", {16'd0, instruction}, 32'hA501);
        chk("pf_pc1", {24'd0, pc}, 32'h1);
        // Advance while the next prefetch is still outstanding: promoted on its ack
        ack_dly = 3;
        tick();
        chk("pf_out_rd", {31'd0, mem_rd}, 32'd1);
        chk("pf_out_addr", {24'd0, mem_addr}, 32'h2);
        pulse();
        chk("pf_out_ready", {31'd0, RAM_ready}, 32'd0);
        chk("pf_out_addr_hold", {24'd0, mem_addr}, 32'h2);
        wait_ready("pf_out_timeout", 20);
        chk("pf_instr2", {16'd0, instruction}, 32'hA502);
        chk("pf_pc2", {24'd0, pc}, 32'h2);
`else
        // Zero-wait advance from S_VALID: bubble of one cycle, word at t+2
        ack_dly = 0;
        pulse();
        chk("t2_pc", {24'd0, pc}, 32'h1);
        chk("t2_ready_low", {31'd0, RAM_ready}, 32'd0);
        chk("t2_mem_rd", {31'd0, mem_rd}, 32'd1);
        chk("t2_mem_addr", {24'd0, mem_addr}, 32'h1);
        tick();
        chk("t2_ready", {31'd0, RAM_ready}, 32'd1);
        chk("t2_instr", {16'd0, instruction}, 32'hA501);

        // Two advances while the read of addr 4 is outstanding
        pulse(); wait_ready("t3_pre2", 10);
        pulse(); wait_ready("t3_pre3", 10);
        chk("t3_pc3", {24'd0, pc}, 32'h3);
        ack_dly = 5;
        pulse();
        chk("t3_addr4", {24'd0, mem_addr}, 32'h4);
        pulse();
        pulse();
        chk("t3_pc6", {24'd0, pc}, 32'h6);
        chk("t3_addr_held", {24'd0, mem_addr}, 32'h4);
        saw6 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (RAM_ready) begin
                got = 1'b1;
                break;
            end
            if (mem_rd && mem_addr == 8'h06) saw6 = 1'b1;
        end
        chk("t3_ready", {31'd0, got}, 32'd1);
        chk("t3_reissue6", {31'd0, saw6}, 32'd1);
        chk("t3_instr", {16'd0, instruction}, 32'hA506);

        // Hold counter_en high up to pc=FF, then wrap
        ack_dly = 0;
        counter_en = 1'b1;
        repeat (249) tick();
        counter_en = 1'b0;
        wait_ready("t4_ff_timeout", 10);
        chk("t4_pcff", {24'd0, pc}, 32'hFF);
        chk("t4_instr_ff", {16'd0, instruction}, 32'hA5FF);
        pulse();
        chk("t4_pc_wrap", {24'd0, pc}, 32'h0);
        chk("t4_addr_wrap", {24'd0, mem_addr}, 32'h0);
        wait_ready("t4_wrap_timeout", 10);
        chk("t4_instr_wrap", {16'd0, instruction}, 32'h1234);

        // Reset mid-transaction with a late ack
        auto_mem = 1'b0;
        man_ack  = 1'b0;
        man_data = 16'hDEAD;
        pulse();
        chk("t5_rd_before", {31'd0, mem_rd}, 32'd1);
        rst = 1'b0;
        tick();
        chk("t5_rd_drop", {31'd0, mem_rd}, 32'd0);
        chk("t5_pc", {24'd0, pc}, 32'h0);
        tick();
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("t5_instr_zero", {16'd0, instruction}, 32'h0);
        chk("t5_ready_low", {31'd0, RAM_ready}, 32'd0);
        auto_mem = 1'b1;
        ack_dly  = 1;
        rst      = 1'b1;
        tick();
        tick();
        chk("t5_refetch_rd", {31'd0, mem_rd}, 32'd1);
        chk("t5_refetch_addr", {24'd0, mem_addr}, 32'h0);
        wait_ready("t5_timeout", 10);
        chk("t5_instr", {16'd0, instruction}, 32'h1234);
`endif

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the control unit. It owns the program counter and issues single-word reads to instruction memory over a request/acknowledge bus. It presents the fetched word on `instruction`, qualified by `RAM_ready`. The control unit's `counter_en` pulse advances the PC and starts the next fetch.

## Interface
- `ADDR_W`, 8: program counter and memory address width.
- `DATA_W`, 16: instruction word width.
- `RESET_PC`, 0: PC value after reset.

- `clk`  input  1  single clock; all logic on posedge.
- `rst`  input  1  synchronous, active-low reset.
- `counter_en`  input  1  from control unit; one-cycle pulse meaning "advance PC by one".
- `mem_rd`  output  1  read request; held high until the cycle `mem_ack` is sampled high.
- `mem_addr`  output  ADDR_W  request address; stable while `mem_rd`=1.
- `mem_ack`  input  1  read complete; sampled only while `mem_rd`=1.
- `mem_rdata`  input  DATA_W  read data; valid in the `mem_ack` cycle.
- `instruction`  output  DATA_W  registered fetched word.
- `RAM_ready`  output  1  `instruction` is the word at the current `pc`.
- `pc`  output  ADDR_W  current program counter.

## Operation
- States:
  - S_RST: reset held.
  - S_REQ: bus read outstanding for `req_addr`.
  - S_VALID: word held, `RAM_ready`=1.
- Reset (`rst`=0) values:
  - `pc`=`req_addr`=`mem_addr`=RESET_PC.
  - `mem_rd`=0, `RAM_ready`=0, `instruction`=0.
  - State goes to S_RST. On the first cycle with `rst`=1 the block enters S_REQ.
- S_REQ:
  - `mem_rd`=1, `mem_addr`=`req_addr`.
  - On `mem_ack`, if `req_addr`==`pc` (PC not advanced): `instruction`<=`mem_rdata`, go to S_VALID.
  - On `mem_ack` with a stale address: discard the data, `req_addr`<=`pc`, remain in S_REQ (new request next cycle).
- `counter_en` in any state: `pc`<=`pc`+1, modulo 2^ADDR_W (2^ADDR_W−1 wraps to 0).
- `counter_en` in S_VALID: `RAM_ready`<=0, `req_addr`<=`pc`+1, go to S_REQ.
- `counter_en` during S_REQ: the PC advances, but `mem_addr` does not change until the current handshake ends. The result is then found stale and the fetch is reissued. Multiple pulses accumulate.
- Simultaneous `mem_ack` and `counter_en` in S_REQ: the acknowledged word is stale (compared against the post-increment PC), so it is discarded.
- Only one transaction is outstanding at a time. `mem_rd` is never dropped before `mem_ack`.
- Reset mid-transaction: `mem_rd` falls the next cycle. A late `mem_ack` is ignored because `mem_rd`=0.

## Timing
- `mem_ack` may arrive in the same cycle `mem_rd` rises (zero-wait memory) or any later cycle.
- Fetch latency: `RAM_ready` rises the cycle after the accepted `mem_ack`.
  - Zero-wait memory: `counter_en` at cycle t → `mem_rd` at t+1 → `RAM_ready` at t+2.
- `RAM_ready` is 0 in the cycle after any `counter_en` unless prefetch supplies the word (see Configuration).
- `instruction` changes only on an accepted word or a prefetch promotion. It never changes while `RAM_ready`=1 without an intervening `counter_en`.

## Configuration
- `FETCH_PREFETCH_EN` defined: one-entry prefetch buffer.
  - In S_VALID with the bus idle, the block reads `pc`+1 into `pf_data` and sets `pf_valid`.
  - `counter_en` with `pf_valid`=1 and `pf_addr`==`pc`+1: `instruction`<=`pf_data`, `RAM_ready` stays 1, `pf_valid`<=0. The next cycle shows the new word with `RAM_ready`=1 (zero-bubble).
  - `counter_en` while the prefetch is outstanding: the prefetch result is promoted on its `mem_ack`, with `RAM_ready`=0 until then.
  - The prefetch is invalidated whenever `pc` moves past `pf_addr`.
- `FETCH_PREFETCH_EN` undefined: no buffer, behaviour exactly as in Operation. The bus is idle in S_VALID.

## Structure
- Package `redcpu_fetch_pkg`: state enum (S_RST, S_REQ, S_VALID) and default widths matching ADDR_W/DATA_W.
- Sub-module `fetch_prefetch_buf`: holds `pf_valid`, `pf_addr`, `pf_data`, plus the hit/invalidate logic. It is instantiated only under `FETCH_PREFETCH_EN`.

## Test plan
- Reset, then release with memory acking 3 cycles after `mem_rd`, word 16'h1234 at addr 0. Expect `mem_addr`=0, `mem_rd` high for 4 cycles, then `instruction`=16'h1234 with `RAM_ready`=1 the cycle after ack.
- Zero-wait memory, `counter_en` pulse in S_VALID. Expect `pc`=1, `RAM_ready`=0 for one cycle, `mem_addr`=1, then the new word with `RAM_ready`=1 at t+2.
- Two `counter_en` pulses during an outstanding read of addr 4. Expect the ack data discarded, a reissue at addr 6, and `RAM_ready` only after the addr-6 ack.
- `pc`=8'hFF, `counter_en`. Expect `pc`=0 and `mem_addr`=0.
- Drive `rst`=0 while `mem_rd`=1, with ack arriving 2 cycles later. Expect `mem_rd`=0 the next cycle, ack ignored, `instruction`=0, and a fetch of RESET_PC after release.
- With `FETCH_PREFETCH_EN`, zero-wait memory, `counter_en` once the prefetch completes. Expect `instruction`=word at pc+1 the next cycle with `RAM_ready` never dropping.
